// File: rtl/btn_cmd_pkg.sv
// Shared constants and types for the push-button command controller.
package btn_cmd_pkg;

    localparam int VAL_W          = 5;
    localparam int DEF_DB_CYCLES  = 4;
    localparam int DEF_RPT_DELAY  = 16;
    localparam int DEF_RPT_PERIOD = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Debounced levels are ordered {up, down, load}.
    typedef struct packed {
        logic [1:0] fsm;
        logic       dir_dn;
        logic [2:0] level;
    } ctrl_dbg_t;

    function automatic int rpt_timer_w(input int delay, input int period);
        return $clog2((delay > period) ? delay : period) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and registered rising-edge detect.
module btn_debounce
    import btn_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES) + 1;

    logic          s1;
    logic          s2;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_q <= level;
            press   <= level & ~level_q;
            // Any sample agreeing with the current level restarts the count.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Turns debounced up/down/load buttons into one-cycle counter commands with
// hold-to-repeat and limit-aware repeat suppression.
module btn_cmd_ctrl
    import btn_cmd_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_UP,
    input  logic             BTN_DN,
    input  logic             BTN_LD,
    input  logic [VAL_W-1:0] SW_IN,
    input  logic             High,
    input  logic             Low,
    output logic             Up,
    output logic             Down,
    output logic             Load,
    output logic [VAL_W-1:0] IN,
    output ctrl_dbg_t        dbg
);

    localparam int TW = rpt_timer_w(RPT_DELAY, RPT_PERIOD);

    logic [2:0]       lvl;
    logic [2:0]       prs;
    logic [VAL_W-1:0] sw_s1;
    logic [VAL_W-1:0] sw_s2;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             dir_dn;
    logic             dir_dn_nx;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_nx;
    logic             up_nx;
    logic             dn_nx;
    logic             ld_nx;
    logic             held;
    logic             expired;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
        .CLK(CLK), .RST(RST), .raw(BTN_LD), .level(lvl[0]), .press(prs[0])
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .CLK(CLK), .RST(RST), .raw(BTN_DN), .level(lvl[1]), .press(prs[1])
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .CLK(CLK), .RST(RST), .raw(BTN_UP), .level(lvl[2]), .press(prs[2])
    );

    assign held    = dir_dn ? lvl[1] : lvl[2];
    assign expired = (state == ST_HOLD) ? (timer == TW'(RPT_DELAY - 1))
                                        : (timer == TW'(RPT_PERIOD - 1));
    assign dbg     = {state, dir_dn, lvl};

    // Priority: load, then a fresh direction press, then release, then the repeat timer.
    always_comb begin
        state_nx  = state;
        dir_dn_nx = dir_dn;
        timer_nx  = timer;
        up_nx     = 1'b0;
        dn_nx     = 1'b0;
        ld_nx     = 1'b0;
        if (prs[0]) begin
            ld_nx    = 1'b1;
            state_nx = ST_IDLE;
            timer_nx = '0;
        end else if (state == ST_IDLE) begin
            if (prs[1] || prs[2]) begin
                dn_nx     = prs[1];
                up_nx     = ~prs[1];
                dir_dn_nx = prs[1];
                timer_nx  = '0;
                state_nx  = ST_HOLD;
            end
        end else if ((prs[1] && !dir_dn) || (prs[2] && dir_dn)) begin
            dn_nx     = ~dir_dn;
            up_nx     = dir_dn;
            dir_dn_nx = ~dir_dn;
            timer_nx  = '0;
            state_nx  = ST_HOLD;
        end else if (!held) begin
            state_nx = ST_IDLE;
            timer_nx = '0;
        end else if (expired) begin
            // At a counter limit the pulse is masked but the cadence keeps running.
            up_nx    = ~dir_dn & ~High;
            dn_nx    = dir_dn & ~Low;
            timer_nx = '0;
            state_nx = ST_REPEAT;
        end else begin
            timer_nx = timer + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            dir_dn <= 1'b0;
            timer  <= '0;
            Up     <= 1'b0;
            Down   <= 1'b0;
            Load   <= 1'b0;
            IN     <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            state  <= state_nx;
            dir_dn <= dir_dn_nx;
            timer  <= timer_nx;
            Up     <= up_nx;
            Down   <= dn_nx;
            Load   <= ld_nx;
            sw_s1  <= SW_IN;
            sw_s2  <= sw_s1;
            if (ld_nx) begin
                IN <= sw_s2;
            end
        end
    end

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Directed and randomized checks of btn_cmd_ctrl against a history-based reference model.
module tb_btn_cmd_ctrl;
    import btn_cmd_pkg::*;

    localparam int DB   = 4;
    localparam int RD   = 16;
    localparam int RP   = 4;
    localparam int MAXC = 8192;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             BTN_UP = 1'b0;
    logic             BTN_DN = 1'b0;
    logic             BTN_LD = 1'b0;
    logic [VAL_W-1:0] SW_IN = '0;
    logic             High = 1'b0;
    logic             Low = 1'b0;
    logic             Up;
    logic             Down;
    logic             Load;
    logic [VAL_W-1:0] IN;
    ctrl_dbg_t        dbg;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int t_ref  = 0;
    int up_log[$];
    int dn_log[$];
    int ld_log[$];
    int exp_q[$];
    logic [VAL_W-1:0] in_at_load = '0;

    // Reference model: raw input history per edge since reset; buttons 0=load 1=down 2=up.
    bit               raw_h [3][MAXC];
    bit               lvl_h [3][MAXC];
    logic [VAL_W-1:0] sw_h  [MAXC];
    int               n    = 0;
    int               mode = 0;   // 0 none, 1 up held, 2 down held
    int               t0   = 0;
    logic             m_up = 1'b0;
    logic             m_dn = 1'b0;
    logic             m_ld = 1'b0;
    logic [VAL_W-1:0] m_in = '0;

    btn_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_LD(BTN_LD),
        .SW_IN(SW_IN), .High(High), .Low(Low), .Up(Up), .Down(Down), .Load(Load),
        .IN(IN), .dbg(dbg)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit raw_at(input int b, input int k);
        if (k < 0) return 1'b0;
        return raw_h[b][k];
    endfunction

    function automatic bit lvl_at(input int b, input int k);
        if (k < 0) return 1'b0;
        return lvl_h[b][k];
    endfunction

    function automatic logic [VAL_W-1:0] sw_at(input int k);
        if (k < 0) return '0;
        return sw_h[k];
    endfunction

    task automatic model_step();
        bit prs [3];
        bit hold [3];
        bit same;
        int e;
        if (!RST) begin
            n = 0; mode = 0; m_up = 1'b0; m_dn = 1'b0; m_ld = 1'b0; m_in = '0;
            return;
        end
        raw_h[0][n] = BTN_LD;
        raw_h[1][n] = BTN_DN;
        raw_h[2][n] = BTN_UP;
        sw_h[n]     = SW_IN;
        for (int b = 0; b < 3; b++) begin
            prs[b]  = lvl_at(b, n - 2) && !lvl_at(b, n - 3);
            hold[b] = lvl_at(b, n - 1);
            // Level follows the synchronized input once DB samples in a row agree.
            same = 1'b1;
            for (int k = 3; k <= DB + 1; k++)
                if (raw_at(b, n - k) != raw_at(b, n - 2)) same = 1'b0;
            lvl_h[b][n] = same ? raw_at(b, n - 2) : lvl_at(b, n - 1);
        end
        m_up = 1'b0; m_dn = 1'b0; m_ld = 1'b0;
        if (prs[0]) begin
            m_ld = 1'b1; m_in = sw_at(n - 2); mode = 0;
        end else if (mode == 1 && prs[1]) begin
            m_dn = 1'b1; mode = 2; t0 = n;
        end else if (mode == 2 && prs[2]) begin
            m_up = 1'b1; mode = 1; t0 = n;
        end else if (mode == 0 && prs[1]) begin
            m_dn = 1'b1; mode = 2; t0 = n;
        end else if (mode == 0 && prs[2]) begin
            m_up = 1'b1; mode = 1; t0 = n;
        end else if (mode != 0 && !hold[(mode == 1) ? 2 : 1]) begin
            mode = 0;
        end else if (mode != 0) begin
            e = n - t0;
            if (e >= RD && (e - RD) % RP == 0) begin
                if (mode == 1) m_up = !High;
                else           m_dn = !Low;
            end
        end
        n++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_log(input string tag, input int got[$], input int want[$]);
        check({tag, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            check(tag, (i < got.size()) ? got[i] : -1, want[i]);
    endtask

    // Driver: one clock edge, model update, then compare just after the edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("up", Up, m_up);
        check("down", Down, m_dn);
        check("load", Load, m_ld);
        check("in", IN, m_in);
        check("level", dbg.level, {lvl_at(2, n - 1), lvl_at(1, n - 1), lvl_at(0, n - 1)});
        if (Up === 1'b1)   up_log.push_back(cyc - t_ref);
        if (Down === 1'b1) dn_log.push_back(cyc - t_ref);
        if (Load === 1'b1) begin
            ld_log.push_back(cyc - t_ref);
            in_at_load = IN;
        end
        cyc++;
    endtask

    task automatic clear_logs();
        up_log.delete();
        dn_log.delete();
        ld_log.delete();
        t_ref = cyc;
    endtask

    initial begin
        int run [3];
        logic [4:0] bounce;

        // Reset state
        #1;
        check("rst_up", Up, 1'b0);
        check("rst_down", Down, 1'b0);
        check("rst_load", Load, 1'b0);
        check("rst_in", IN, '0);
        check("rst_fsm", dbg.fsm, ST_IDLE);
        repeat (3) tick();
        RST = 1'b1;
        repeat (4) tick();

        // Bounce 1-0-1 then only three stable high samples: never debounced
        clear_logs();
        bounce = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            BTN_UP = bounce[i];
            tick();
        end
        BTN_UP = 1'b0;
        repeat (20) tick();
        check("bounce_no_up", up_log.size(), 0);

        // Clean press held 40 cycles: initial pulse, delay, then periodic repeats
        clear_logs();
        BTN_UP = 1'b1;
        repeat (40) tick();
        BTN_UP = 1'b0;
        repeat (20) tick();
        exp_q = {7, 23, 27, 31, 35, 39, 43};
        check_log("rpt_up", up_log, exp_q);

        // Load captures the synchronized switches and holds them afterwards
        SW_IN = 5'b10110;
        repeat (3) tick();
        clear_logs();
        BTN_LD = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 8) SW_IN = 5'b01001;
        end
        BTN_LD = 1'b0;
        repeat (20) tick();
        exp_q = {7};
        check_log("load", ld_log, exp_q);
        check("load_value", in_at_load, 5'b10110);
        check("in_hold", IN, 5'b10110);

        // Simultaneous presses: load wins, others discarded
        clear_logs();
        BTN_LD = 1'b1; BTN_DN = 1'b1; BTN_UP = 1'b1;
        repeat (10) tick();
        BTN_LD = 1'b0; BTN_DN = 1'b0; BTN_UP = 1'b0;
        repeat (20) tick();
        exp_q = {7};
        check_log("prio_load", ld_log, exp_q);
        check("prio_no_up", up_log.size(), 0);
        check("prio_no_down", dn_log.size(), 0);

        // Down held at the lower limit: repeats masked until Low clears
        clear_logs();
        Low = 1'b1;
        BTN_DN = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 30) Low = 1'b0;
        end
        BTN_DN = 1'b0;
        repeat (20) tick();
        exp_q = {7, 31, 35, 39, 43};
        check_log("low_dn", dn_log, exp_q);

        // Reset in the middle of repeat with the button still held
        clear_logs();
        BTN_UP = 1'b1;
        repeat (32) tick();
        check("pre_rst_up", Up, 1'b1);
        #2 RST = 1'b0;
        #1;
        check("midrst_up", Up, 1'b0);
        check("midrst_fsm", dbg.fsm, ST_IDLE);
        check("midrst_level", dbg.level, 3'b000);
        check("midrst_in", IN, '0);
        repeat (3) tick();
        RST = 1'b1;
        clear_logs();
        repeat (12) tick();
        exp_q = {7};
        check_log("post_rst_up", up_log, exp_q);
        BTN_UP = 1'b0;
        repeat (20) tick();

        // Randomized bouncing buttons, limit flags and switches against the model
        for (int b = 0; b < 3; b++) run[b] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (run[b] == 0) begin
                    case (b)
                        0: BTN_LD = ~BTN_LD;
                        1: BTN_DN = ~BTN_DN;
                        default: BTN_UP = ~BTN_UP;
                    endcase
                    run[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(5, 60);
                end else begin
                    run[b]--;
                end
            end
            if ($urandom_range(0, 49) == 0) High = ~High;
            if ($urandom_range(0, 49) == 0) Low = ~Low;
            if ($urandom_range(0, 7) == 0) SW_IN = 5'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
